// File: rtl/frog_lane_arbiter.sv
// Frame-rate game-state stage: per-lane car motion and frog collision, PLAY/HIT/OVER
// control, score/lives ownership and the frog respawn pulse.

module frog_lane_car #(
  parameter int K          = 0,
  parameter int LANE_Y     = 64,
  parameter int CAR_W      = 64,
  parameter int FROG_W     = 32,
  parameter int SCREEN_W   = 640
) (
  input  logic       clk,
  input  logic       init_i,
  input  logic       adv_i,
  input  logic [9:0] frog_x_i,
  input  logic [9:0] frog_y_i,
  output logic [9:0] x_o,
  output logic       hit_o
);
  localparam logic [10:0] V    = 11'(K + 1);
  localparam logic [10:0] SW   = 11'(SCREEN_W);
  localparam logic [10:0] CW   = 11'(CAR_W);
  localparam logic [10:0] FW   = 11'(FROG_W);
  localparam logic [9:0]  LY   = 10'(LANE_Y);
  localparam logic [9:0]  INIT = 10'((160 * K) % SCREEN_W);

  logic [9:0]  x_q, x_d;
  logic [10:0] x11, fx11, sum;

  assign x11  = {1'b0, x_q};
  assign fx11 = {1'b0, frog_x_i};
  assign sum  = x11 + V;

  // Even lanes drift right, odd lanes left; both wrap on SCREEN_W.
  always_comb begin
    x_d = x_q;
    if ((K % 2) == 0) x_d = (sum >= SW) ? 10'(sum - SW) : 10'(sum);
    else              x_d = (x11 < V) ? 10'(x11 + SW - V) : 10'(x11 - V);
  end

  always_ff @(posedge clk) begin
    if (init_i)     x_q <= INIT;
    else if (adv_i) x_q <= x_d;
  end

  assign x_o   = x_q;
  assign hit_o = (frog_y_i == LY) && (fx11 < x11 + CW) && (x11 < fx11 + FW);
endmodule

module frog_lane_arbiter #(
  parameter int NUM_LANES    = 4,
  parameter int LANE_Y0      = 64,
  parameter int LANE_PITCH   = 32,
  parameter int CAR_W        = 64,
  parameter int FROG_W       = 32,
  parameter int SCREEN_W     = 640,
  parameter int GOAL_Y       = 0,
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int SCORE_MAX    = 99
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Frame_Tick,
  input  logic                    i_Start,
  input  logic [9:0]              i_Frog_X,
  input  logic [9:0]              i_Frog_Y,
  output logic [10*NUM_LANES-1:0] o_Car_X,
  output logic                    o_Frog_Respawn,
  output logic                    o_Frog_Freeze,
  output logic [6:0]              o_Score,
  output logic [1:0]              o_Lives,
  output logic                    o_Game_Over
);
  localparam int CNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [6:0] SMAX   = 7'(SCORE_MAX);
  localparam logic [1:0] LIVES0 = 2'(START_LIVES);
  localparam logic [9:0] GOAL   = 10'(GOAL_Y);

  typedef enum logic [1:0] {PLAY, HIT, OVER} state_e;

  state_e                         state_q, state_d;
  logic [6:0]                     score_q, score_d;
  logic [1:0]                     lives_q, lives_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           resp_q, resp_d;
  logic                           restart, adv, any_hit;
  logic [NUM_LANES-1:0]           hit;
  logic [NUM_LANES-1:0][9:0]      car_x;

  assign adv = i_Frame_Tick && (state_q == PLAY);

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      frog_lane_car #(
        .K(k), .LANE_Y(LANE_Y0 + k * LANE_PITCH), .CAR_W(CAR_W),
        .FROG_W(FROG_W), .SCREEN_W(SCREEN_W)
      ) u_car (
        .clk     (i_Clk),
        .init_i  (i_Reset || restart),
        .adv_i   (adv),
        .frog_x_i(i_Frog_X),
        .frog_y_i(i_Frog_Y),
        .x_o     (car_x[k]),
        .hit_o   (hit[k])
      );
    end
  endgenerate

  assign any_hit = |hit;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    resp_d  = 1'b0;
    restart = 1'b0;
    case (state_q)
      PLAY: if (i_Frame_Tick) begin
        if (any_hit) begin
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          if (lives_q <= 2'd1) state_d = OVER;
          else begin
            state_d = HIT;
            cnt_d   = '0;
          end
        end else if (i_Frog_Y == GOAL) begin
          score_d = (score_q >= SMAX) ? SMAX : score_q + 7'd1;
          resp_d  = 1'b1;
        end
      end
      HIT: if (i_Frame_Tick) begin
        if (cnt_q == CNT_LAST) begin
          state_d = PLAY;
          resp_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      OVER: if (i_Start) begin
        restart = 1'b1;
        state_d = PLAY;
        score_d = '0;
        lives_d = LIVES0;
        cnt_d   = '0;
        resp_d  = 1'b1;
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= PLAY;
      score_q <= '0;
      lives_q <= LIVES0;
      cnt_q   <= '0;
      resp_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      // Back-to-back ticks must not stretch the respawn pulse.
      resp_q  <= resp_d && !resp_q;
    end
  end

  assign o_Car_X        = car_x;
  assign o_Frog_Respawn = resp_q;
  assign o_Frog_Freeze  = (state_q != PLAY);
  assign o_Game_Over    = (state_q == OVER);
  assign o_Score        = score_q;
  assign o_Lives        = lives_q;
endmodule

// File: tb/tb_frog_lane_arbiter.sv
// Cycle scoreboard for frog_lane_arbiter: a behavioural model pushes the expected
// registered outputs per driven cycle; they are popped and compared after the edge.

module tb_frog_lane_arbiter;
  logic        i_Clk = 1'b0;
  logic        i_Reset, i_Frame_Tick, i_Start;
  logic [9:0]  i_Frog_X, i_Frog_Y;
  logic [39:0] o_Car_X;
  logic        o_Frog_Respawn, o_Frog_Freeze, o_Game_Over;
  logic [6:0]  o_Score;
  logic [1:0]  o_Lives;

  always #5 i_Clk = ~i_Clk;

  frog_lane_arbiter dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Frame_Tick(i_Frame_Tick), .i_Start(i_Start),
    .i_Frog_X(i_Frog_X), .i_Frog_Y(i_Frog_Y), .o_Car_X(o_Car_X),
    .o_Frog_Respawn(o_Frog_Respawn), .o_Frog_Freeze(o_Frog_Freeze), .o_Score(o_Score),
    .o_Lives(o_Lives), .o_Game_Over(o_Game_Over)
  );

  typedef struct {
    logic [39:0] cx;
    int          score, lives;
    bit          frz, go, resp;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;

  // model state: st 0=PLAY 1=HIT 2=OVER
  int mx[4];
  int mst, mscore, mlives, mcnt;
  bit mresp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_init();
    for (int k = 0; k < 4; k++) mx[k] = (160 * k) % 640;
    mst = 0; mscore = 0; mlives = 3; mcnt = 0; mresp = 1;
  endfunction

  function automatic void m_step(bit tk, bit st, bit rs, int fx, int fy);
    bit hit, rn;
    if (rs) begin m_init(); return; end
    rn = 0;
    if (mst == 2) begin
      if (st) begin m_init(); return; end
    end else if (tk && mst == 0) begin
      hit = 0;
      for (int k = 0; k < 4; k++)
        if (fy == 64 + 32 * k && fx < mx[k] + 64 && mx[k] < fx + 32) hit = 1;
      for (int k = 0; k < 4; k++) begin
        if (k % 2 == 0) mx[k] = (mx[k] + k + 1) % 640;
        else            mx[k] = (mx[k] - (k + 1) + 640) % 640;
      end
      if (hit) begin
        if (mlives > 0) mlives--;
        if (mlives == 0) mst = 2;
        else begin mst = 1; mcnt = 0; end
      end else if (fy == 0) begin
        mscore = (mscore + 1 > 99) ? 99 : mscore + 1;
        rn = 1;
      end
    end else if (tk && mst == 1) begin
      if (mcnt == 59) begin mst = 0; rn = 1; end
      else mcnt++;
    end
    mresp = rn && !mresp;
  endfunction

  task automatic step(input bit tk, input bit st, input bit rs, input int fx, input int fy);
    exp_t e, o;
    i_Frame_Tick = tk; i_Start = st; i_Reset = rs;
    i_Frog_X = 10'(fx); i_Frog_Y = 10'(fy);
    m_step(tk, st, rs, fx, fy);
    for (int k = 0; k < 4; k++) e.cx[10*k +: 10] = 10'(mx[k]);
    e.score = mscore; e.lives = mlives;
    e.frz = (mst != 0); e.go = (mst == 2); e.resp = mresp;
    q.push_back(e);
    @(posedge i_Clk);
    #1;
    o = q.pop_front();
    chk("car_x",   64'(o_Car_X),        64'(o.cx));
    chk("score",   64'(o_Score),        64'(o.score));
    chk("lives",   64'(o_Lives),        64'(o.lives));
    chk("freeze",  64'(o_Frog_Freeze),  64'(o.frz));
    chk("gameover",64'(o_Game_Over),    64'(o.go));
    chk("respawn", 64'(o_Frog_Respawn), 64'(o.resp));
  endtask

  task automatic tick(input int fx, input int fy);
    step(1, 0, 0, fx, fy);
    step(0, 0, 0, fx, fy);
  endtask

  task automatic reset_dut();
    step(0, 0, 1, 0, 500);
    step(0, 0, 0, 0, 500);
  endtask

  initial begin
    i_Reset = 1; i_Frame_Tick = 0; i_Start = 0; i_Frog_X = 0; i_Frog_Y = 500;
    m_init();
    reset_dut();
    // motion after reset, with hard-coded spot checks alongside the model
    for (int i = 0; i < 3; i++) tick(0, 500);
    chk("t1_car0", 64'(o_Car_X[9:0]), 64'd3);
    chk("t1_car1", 64'(o_Car_X[19:10]), 64'd154);
    step(0, 1, 0, 0, 500);                 // start ignored in PLAY
    for (int i = 3; i < 700; i++) tick(0, 500);  // spans both wrap seams

    // hit on lane 0, full death freeze, return to PLAY
    reset_dut();
    tick(60, 64);
    chk("t3_lives", 64'(o_Lives), 64'd2);
    chk("t3_freeze", 64'(o_Frog_Freeze), 64'd1);
    step(0, 1, 0, 0, 500);                 // start ignored in HIT
    for (int i = 0; i < 60; i++) tick(0, 500);
    chk("t3_play", 64'(o_Frog_Freeze), 64'd0);

    // touching edge is not a hit; goal scores
    reset_dut();
    tick(64, 64);
    chk("t4_nohit", 64'(o_Lives), 64'd3);
    step(1, 0, 0, 64, 0);
    chk("t4_resp", 64'(o_Frog_Respawn), 64'd1);
    step(0, 0, 0, 64, 0);
    chk("t4_score", 64'(o_Score), 64'd1);

    // score saturation, lives to zero on successive lanes, OVER, restart
    reset_dut();
    for (int i = 0; i < 101; i++) tick(100, 0);
    chk("t5_sat", 64'(o_Score), 64'd99);
    for (int h = 0; h < 3; h++) begin
      tick(mx[h], 64 + 32 * h);
      if (h < 2) for (int i = 0; i < 60; i++) tick(0, 500);
    end
    chk("t5_over", 64'(o_Game_Over), 64'd1);
    for (int i = 0; i < 4; i++) tick(100, 0);
    step(0, 1, 0, 0, 500);
    chk("t5_restart_lives", 64'(o_Lives), 64'd3);
    step(0, 0, 0, 0, 500);
    tick(0, 500);

    // reset during HIT
    tick(mx[1], 96);
    for (int i = 0; i < 30; i++) tick(0, 500);
    step(0, 0, 1, 0, 500);
    chk("t6_freeze", 64'(o_Frog_Freeze), 64'd0);
    for (int i = 0; i < 3; i++) tick(0, 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
